// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, ALU operation codes and FSM encoding for the ALU sequencer.
// The ADC2 state exists only when ALU_CTRL_ADC_EN is defined.
package alu_ctrl_pkg;

  localparam int ALU_W = 8;
  localparam int REG_N = 8;

  localparam logic [3:0] OPC_ST  = 4'h8;
  localparam logic [3:0] OPC_LDI = 4'h9;
  localparam logic [3:0] OPC_CLC = 4'hA;
  localparam logic [3:0] OPC_ADC = 4'hB;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOT  = 4'b0101;
  localparam logic [3:0] ALU_PASS = 4'b0110;
  localparam logic [3:0] ALU_NOP  = 4'b0111;

`ifdef ALU_CTRL_ADC_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH_IMM = 2'd1,
    ST_EXEC      = 2'd2,
    ST_ADC2      = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH_IMM = 2'd1,
    ST_EXEC      = 2'd2
  } state_t;
`endif

  // ALU code presented during EXEC for a given instruction opcode.
  function automatic logic [3:0] decode_op(input logic [3:0] opc);
    logic [3:0] op;
    op = ALU_NOP;
    if (!opc[3]) begin
      op = {1'b0, opc[2:0]};
    end else if (opc == OPC_LDI) begin
      op = ALU_PASS;
`ifdef ALU_CTRL_ADC_EN
    end else if (opc == OPC_ADC) begin
      op = ALU_ADD;
`endif
    end
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// Operand register file: one synchronous write port, one asynchronous read port.
// Latency: read combinational, write visible after the clock edge. No backpressure.
module alu_ctrl_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_ctrl.sv
// Instruction sequencer for the external 8-bit ALU; optional ADC behind macro ALU_CTRL_ADC_EN.
// Latency: result written one edge after the instruction byte is taken; in_ready low while executing.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_r,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cy,
  output logic [DATA_W-1:0] acc,
  output logic              cy_flag,
  output logic              busy
);

  if (DATA_W != ALU_W) begin : g_bad_width
    $error("alu_ctrl: DATA_W must be 8 to match the ALU");
  end
  if (NREGS != REG_N) begin : g_bad_depth
    $error("alu_ctrl: NREGS must be 8, the index field is 3 bits");
  end

  state_t            state;
  logic [3:0]        opc_q;
  logic [2:0]        idx_q;
  logic              accept;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata;
  logic              unused_bit3;

  assign accept      = in_valid & in_ready;
  assign unused_bit3 = in_data[3];
  assign alu_a       = acc;
  assign rf_we       = (state == ST_EXEC) && (opc_q == OPC_ST);

  // Read address comes straight off the byte so the operand is captured on the accept edge.
  alu_ctrl_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (idx_q),
    .wdata (acc),
    .raddr (in_data[2:0]),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      opc_q    <= '0;
      idx_q    <= '0;
      acc      <= '0;
      cy_flag  <= 1'b0;
      alu_op   <= ALU_NOP;
      alu_r    <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            opc_q <= in_data[7:4];
            idx_q <= in_data[2:0];
            alu_r <= rf_rdata;
            busy  <= 1'b1;
            if (in_data[7:4] == OPC_LDI) begin
              state <= ST_FETCH_IMM;
            end else begin
              state    <= ST_EXEC;
              in_ready <= 1'b0;
              alu_op   <= decode_op(in_data[7:4]);
            end
          end
        end

        ST_FETCH_IMM: begin
          if (accept) begin
            alu_r    <= in_data;
            alu_op   <= ALU_PASS;
            in_ready <= 1'b0;
            state    <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          state    <= ST_IDLE;
          alu_op   <= ALU_NOP;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (!opc_q[3]) begin
            case ({1'b0, opc_q[2:0]})
              ALU_ADD, ALU_SUB: begin
                acc     <= alu_out;
                cy_flag <= alu_cy;
              end
              ALU_AND, ALU_OR, ALU_XOR, ALU_NOT: begin
                acc     <= alu_out;
                cy_flag <= 1'b0;
              end
              ALU_PASS: acc <= alu_r;
              default: ;
            endcase
          end else begin
            case (opc_q)
              OPC_LDI: acc <= alu_out;
              OPC_CLC: cy_flag <= 1'b0;
`ifdef ALU_CTRL_ADC_EN
              // Carry-in is the flag before this edge; a set carry costs one extra +1 pass.
              OPC_ADC: begin
                acc     <= alu_out;
                cy_flag <= alu_cy;
                if (cy_flag) begin
                  state    <= ST_ADC2;
                  alu_op   <= ALU_ADD;
                  alu_r    <= DATA_W'(1);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end

`ifdef ALU_CTRL_ADC_EN
        ST_ADC2: begin
          acc      <= alu_out;
          cy_flag  <= cy_flag | alu_cy;
          state    <= ST_IDLE;
          alu_op   <= ALU_NOP;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
`endif

        default: begin
          state    <= ST_IDLE;
          alu_op   <= ALU_NOP;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
